// File: rtl/bp_cce_dir_sharers_scanner.sv
// Multi-cycle CCE directory lookup: scans the rows of one set, tag-compares every way in parallel,
// and accumulates per-LCE sharers hit/way/state. Optional multi-hit flag: BP_CCE_DIR_MULTI_HIT_CHECK_EN.

module bp_cce_dir_sharers_scanner_set
  #(parameter int assoc_p     = 8
  , parameter int tag_width_p = 28
  , parameter int coh_width_p = 3
  , parameter int lg_assoc_p  = 3
  , localparam int entry_width_lp = tag_width_p + coh_width_p
  )
  (input  logic [assoc_p*entry_width_lp-1:0] entries
  , input  logic [tag_width_p-1:0]           tag
  , input  logic                             v
  , output logic [assoc_p-1:0]               way_hits
  , output logic [lg_assoc_p-1:0]            way
  , output logic [coh_width_p-1:0]           state
  );

    always_comb begin
        way_hits = '0;
        way      = '0;
        state    = '0;
        // Invalid (e_COH_I) encodes as all-zero, so a nonzero state means the line is live
        for (int j = 0; j < assoc_p; j++) begin
            way_hits[j] = v
                && (entries[j*entry_width_lp+coh_width_p +: tag_width_p] == tag)
                && (entries[j*entry_width_lp +: coh_width_p] != '0);
        end
        for (int j = assoc_p-1; j >= 0; j--) begin
            if (way_hits[j]) begin
                way   = lg_assoc_p'(j);
                state = entries[j*entry_width_lp +: coh_width_p];
            end
        end
    end

endmodule

module bp_cce_dir_sharers_scanner
  #(parameter int num_lce_p          = 8
  , parameter int tag_sets_per_row_p = 2
  , parameter int assoc_p            = 8
  , parameter int tag_width_p        = 28
  , localparam int coh_width_lp   = 3
  , localparam int entry_width_lp = tag_width_p + coh_width_lp
  , localparam int row_width_lp   = tag_sets_per_row_p*assoc_p*entry_width_lp
  , localparam int rows_lp        = (num_lce_p + tag_sets_per_row_p - 1) / tag_sets_per_row_p
  , localparam int lg_assoc_lp    = (assoc_p == 1) ? 1 : $clog2(assoc_p)
  )
  (input  logic                                clk_i
  , input  logic                                reset_i
  , input  logic [tag_width_p-1:0]              tag_i
  , input  logic                                start_v_i
  , output logic                                ready_and_o
  , input  logic [row_width_lp-1:0]             row_i
  , input  logic [tag_sets_per_row_p-1:0]       row_v_i
  , input  logic                                row_valid_i
  , output logic                                row_ready_and_o
  , output logic                                v_o
  , input  logic                                yumi_i
  , output logic [num_lce_p-1:0]                sharers_hits_o
  , output logic [num_lce_p*lg_assoc_lp-1:0]    sharers_ways_o
  , output logic [num_lce_p*coh_width_lp-1:0]   sharers_coh_states_o
  , output logic                                error_o
  );

    typedef enum logic [2:0] {
        e_COH_I = 3'b000, e_COH_S = 3'b001, e_COH_E = 3'b010,
        e_COH_F = 3'b011, e_COH_M = 3'b110, e_COH_O = 3'b111
    } bp_coh_states_e;

    localparam int cnt_width_lp = (rows_lp > 1) ? $clog2(rows_lp) : 1;

    localparam logic [1:0] e_ready = 2'd0;
    localparam logic [1:0] e_scan  = 2'd1;
    localparam logic [1:0] e_done  = 2'd2;

    logic [1:0]                              state_r;
    logic [cnt_width_lp-1:0]                 row_cnt_r;
    logic [tag_width_p-1:0]                  tag_r;
    logic [num_lce_p-1:0]                    hits_r;
    logic [num_lce_p*lg_assoc_lp-1:0]        ways_r;
    logic [num_lce_p*coh_width_lp-1:0]       states_r;

    logic [tag_sets_per_row_p-1:0][assoc_p-1:0]      set_way_hits;
    logic [tag_sets_per_row_p-1:0][lg_assoc_lp-1:0]  set_way;
    logic [tag_sets_per_row_p-1:0][coh_width_lp-1:0] set_state;

    wire start_hs = (state_r == e_ready) && start_v_i;
    wire row_hs   = (state_r == e_scan) && row_valid_i;
    wire last_row = (row_cnt_r == cnt_width_lp'(rows_lp-1));

    assign ready_and_o          = (state_r == e_ready);
    assign row_ready_and_o      = (state_r == e_scan);
    assign v_o                  = (state_r == e_done);
    assign sharers_hits_o       = hits_r;
    assign sharers_ways_o       = ways_r;
    assign sharers_coh_states_o = states_r;

    for (genvar i = 0; i < tag_sets_per_row_p; i++) begin : g_set
        bp_cce_dir_sharers_scanner_set
          #(.assoc_p(assoc_p), .tag_width_p(tag_width_p)
          , .coh_width_p(coh_width_lp), .lg_assoc_p(lg_assoc_lp))
          u_set
          (.entries(row_i[i*assoc_p*entry_width_lp +: assoc_p*entry_width_lp])
          , .tag(tag_r)
          , .v(row_v_i[i])
          , .way_hits(set_way_hits[i])
          , .way(set_way[i])
          , .state(set_state[i])
          );
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= e_ready;
            row_cnt_r <= '0;
            tag_r     <= '0;
            hits_r    <= '0;
            ways_r    <= '0;
            states_r  <= {num_lce_p{e_COH_I}};
        end else begin
            case (state_r)
                e_ready: if (start_hs) begin
                    tag_r     <= tag_i;
                    row_cnt_r <= '0;
                    hits_r    <= '0;
                    ways_r    <= '0;
                    states_r  <= {num_lce_p{e_COH_I}};
                    state_r   <= e_scan;
                end
                e_scan: if (row_hs) begin
                    // Tag set i of this row belongs to LCE row_cnt*sets+i; padding sets never match an l
                    for (int l = 0; l < num_lce_p; l++) begin
                        for (int i = 0; i < tag_sets_per_row_p; i++) begin
                            if (int'(row_cnt_r)*tag_sets_per_row_p + i == l) begin
                                hits_r[l]                               <= |set_way_hits[i];
                                ways_r[l*lg_assoc_lp +: lg_assoc_lp]    <= set_way[i];
                                states_r[l*coh_width_lp +: coh_width_lp] <= set_state[i];
                            end
                        end
                    end
                    row_cnt_r <= row_cnt_r + 1'b1;
                    if (last_row)
                        state_r <= e_done;
                end
                e_done: if (yumi_i)
                    state_r <= e_ready;
                default: state_r <= e_ready;
            endcase
        end
    end

`ifdef BP_CCE_DIR_MULTI_HIT_CHECK_EN
    logic error_r;
    logic row_multi;

    always_comb begin
        row_multi = 1'b0;
        for (int i = 0; i < tag_sets_per_row_p; i++) begin
            if (int'(row_cnt_r)*tag_sets_per_row_p + i < num_lce_p)
                row_multi = row_multi
                    | ((set_way_hits[i] & (set_way_hits[i] - 1'b1)) != '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            error_r <= 1'b0;
        else if (start_hs)
            error_r <= 1'b0;
        else if (row_hs && row_multi)
            error_r <= 1'b1;
    end

    assign error_o = error_r;
`else
    assign error_o = 1'b0;
`endif

endmodule
